cpu6_bus_arbiter: RTL

//  Shares the system memory bus (16-bit address, 8-bit write data, write strobe) between the CPU6 core and
//  NUM_REQ DMA requesters (disk/console controllers). The CPU owns the bus by default. A DMA request holds the
//  CPU via a hold/ack handshake, grants one requester round-robin for a bounded burst, then returns the bus.

---
 rtl/cpu6_bus_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cpu6_bus_arbiter.sv
// Memory bus arbiter between the CPU6 core and NUM_REQ DMA requesters.
// The CPU owns the bus by default; DMA takes it via hold/ack for one bounded round-robin burst.
module cpu6_bus_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned MAX_BURST      = 4,
    parameter int unsigned CPU_MIN_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [15:0]           cpu_address,
    input  logic [7:0]            cpu_data_out,
    input  logic                  cpu_write_en,
    output logic                  cpu_hold,
    input  logic                  cpu_hold_ack,
    input  logic [NUM_REQ-1:0]    dma_req,
    input  logic [NUM_REQ-1:0]    dma_last,
    input  logic [16*NUM_REQ-1:0] dma_address,
    input  logic [8*NUM_REQ-1:0]  dma_data_out,
    input  logic [NUM_REQ-1:0]    dma_write_en,
    output logic [NUM_REQ-1:0]    dma_grant,
    output logic [15:0]           mem_address,
    output logic [7:0]            mem_data_out,
    output logic                  mem_write_en,
    output logic                  dma_active
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StCpuOwn, StHoldReq, StDmaOwn, StRelease} state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IdxW-1:0]      gidx_q, gidx_d;
    logic [IdxW-1:0]      rr_q, rr_d;
    logic [7:0]           burst_q, burst_d;
    logic [7:0]           cmin_q, cmin_d;

    logic                 win_found;
    logic [IdxW-1:0]      win_idx;
    logic [15:0]          sel_addr;
    logic [7:0]           sel_data;
    logic                 sel_we;
    logic                 sel_req;
    logic                 sel_last;
    logic                 burst_end;

    // Round-robin search: first requester strictly after rr_q, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!win_found && dma_req[j] && (j == (32'(rr_q) + k) % NUM_REQ)) begin
                    win_found = 1'b1;
                    win_idx   = IdxW'(j);
                end
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_we   = 1'b0;
        sel_req  = 1'b0;
        sel_last = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gidx_q == IdxW'(i)) begin
                sel_addr = dma_address[16*i +: 16];
                sel_data = dma_data_out[8*i +: 8];
                sel_we   = dma_write_en[i];
                sel_req  = dma_req[i];
                sel_last = dma_last[i];
            end
        end
    end

    assign burst_end = sel_last || !sel_req || (burst_q == 8'(MAX_BURST - 1));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        rr_d    = rr_q;
        burst_d = burst_q;
        cmin_d  = cmin_q;
        unique case (state_q)
            StCpuOwn: begin
                if (cmin_q != 8'(CPU_MIN_CYCLES)) begin
                    cmin_d = cmin_q + 8'd1;
                end
                if (|dma_req && (cmin_q == 8'(CPU_MIN_CYCLES))) begin
                    state_d = StHoldReq;
                end
            end
            StHoldReq: begin
                if (cpu_hold_ack) begin
                    if (win_found) begin
                        grant_d          = '0;
                        grant_d[win_idx] = 1'b1;
                        gidx_d           = win_idx;
                        rr_d             = win_idx;
                        burst_d          = '0;
                        state_d          = StDmaOwn;
                    end else begin
                        state_d = StRelease;
                    end
                end
            end
            StDmaOwn: begin
                if (burst_end) begin
                    grant_d = '0;
                    state_d = StRelease;
                end else begin
                    burst_d = burst_q + 8'd1;
                end
            end
            StRelease: begin
                grant_d = '0;
                cmin_d  = '0;
                state_d = StCpuOwn;
            end
            default: state_d = StCpuOwn;
        endcase
    end

    // CPU-min count resets saturated so the first hold after reset is not delayed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StCpuOwn;
            grant_q <= '0;
            gidx_q  <= '0;
            rr_q    <= IdxW'(NUM_REQ - 1);
            burst_q <= '0;
            cmin_q  <= 8'(CPU_MIN_CYCLES);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
            cmin_q  <= cmin_d;
        end
    end

    always_comb begin
        mem_address  = cpu_address;
        mem_data_out = cpu_data_out;
        mem_write_en = cpu_write_en;
        unique case (state_q)
            StDmaOwn: begin
                mem_address  = sel_addr;
                mem_data_out = sel_data;
                mem_write_en = sel_we & sel_req;
            end
            // Turnaround cycle: CPU drives address/data but no write can land.
            StRelease: mem_write_en = 1'b0;
            default: ;
        endcase
    end

    assign cpu_hold   = (state_q == StHoldReq) || (state_q == StDmaOwn);
    assign dma_active = (state_q == StDmaOwn);
    assign dma_grant  = grant_q;

endmodule
